lockin_ctrl_regs: RTL and testbench

Parametrised control register bank for the multi-lock-in datapath. It is the successor to the fixed-width PIO exports for gain control and per-channel phase increment/offset. An Avalon-MM slave writes shadow registers for NUM_CH lock-in channels plus a shared gain word. A commit state machine copies all shadows to the live outputs in one clock edge, either immediately or on the next external sample-aligned sync strobe, so the NCOs never see a partially updated channel set.

---
 rtl/lockin_ctrl_regs.sv | 194 +++++++++++++++++++
 tb/tb_lockin_ctrl_regs.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lockin_ctrl_regs.sv
`default_nettype none
// ============================================================================
// Module   : lockin_ctrl_regs
// Purpose  : Avalon-MM shadow register bank for the multi-lock-in datapath,
//            with atomic shadow->live commit (immediate or sync-aligned).
// Options  : LOCKIN_REGS_READBACK_EN - enables shadow/STATUS readback data.
// Revision : 1.0 - initial release
// ============================================================================
module lockin_ctrl_regs #(
  parameter int NUM_CH   = 8,
  parameter int PHASE_W  = 20,
  parameter int GAIN_W   = 6,
  parameter int GAIN_RST = 0
) (
  input  logic                        clk_clk,
  input  logic                        reset_reset,
  input  logic [5:0]                  avs_address,
  input  logic                        avs_write,
  input  logic [31:0]                 avs_writedata,
  input  logic                        avs_read,
  output logic [31:0]                 avs_readdata,
  output logic                        avs_readdatavalid,
  input  logic                        sync_strobe,
  output logic [NUM_CH*PHASE_W-1:0]   phase_incr,
  output logic [NUM_CH*PHASE_W-1:0]   phase_offs,
  output logic [GAIN_W-1:0]           gain_ctrl,
  output logic                        update_pulse,
  output logic                        commit_pending
);

  localparam logic [GAIN_W-1:0] c_GAIN_RST = GAIN_RST[GAIN_W-1:0];
  localparam logic [5:0]        c_ADDR_CTRL   = 6'h00;
  localparam logic [5:0]        c_ADDR_STATUS = 6'h01;
  localparam logic [5:0]        c_ADDR_GAIN   = 6'h02;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_LOAD  = 2'd2
  } state_t;

  state_t                      r_state;
  logic [PHASE_W-1:0]          r_sh_incr [NUM_CH];
  logic [PHASE_W-1:0]          r_sh_offs [NUM_CH];
  logic [GAIN_W-1:0]           r_sh_gain;
  logic [NUM_CH*PHASE_W-1:0]   r_live_incr;
  logic [NUM_CH*PHASE_W-1:0]   r_live_offs;
  logic [GAIN_W-1:0]           r_live_gain;
  logic [15:0]                 r_commit_cnt;
  logic                        r_update_pulse;
  logic [31:0]                 r_rdata;
  logic                        r_rdvalid;

  logic                        w_ctrl_wr;
  logic                        w_abort;
  logic                        w_commit;
  logic                        w_imm;
  logic                        w_gain_wr;
  logic                        w_incr_wr;
  logic                        w_offs_wr;
  logic [3:0]                  w_ch;
  logic                        w_pending;
  logic                        w_unused_wdata;

  assign w_ctrl_wr = avs_write && (avs_address == c_ADDR_CTRL);
  assign w_abort   = w_ctrl_wr && avs_writedata[2];
  // ABORT wins over COMMIT when both bits arrive in one write
  assign w_commit  = w_ctrl_wr && avs_writedata[0] && !avs_writedata[2];
  assign w_imm     = avs_writedata[1];
  assign w_gain_wr = avs_write && (avs_address == c_ADDR_GAIN);
  assign w_incr_wr = avs_write && (avs_address[5:4] == 2'b01);
  assign w_offs_wr = avs_write && (avs_address[5:4] == 2'b10);
  assign w_ch      = avs_address[3:0];
  assign w_pending = (r_state != ST_IDLE);

  assign w_unused_wdata = ^avs_writedata;

  // Commit FSM and live registers
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      r_state        <= ST_IDLE;
      r_live_incr    <= '0;
      r_live_offs    <= '0;
      r_live_gain    <= c_GAIN_RST;
      r_commit_cnt   <= 16'd0;
      r_update_pulse <= 1'b0;
    end else begin
      r_update_pulse <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_commit) begin
            r_state <= w_imm ? ST_LOAD : ST_ARMED;
          end
        end
        ST_ARMED: begin
          if (w_abort) begin
            r_state <= ST_IDLE;
          end else if (sync_strobe || (w_commit && w_imm)) begin
            r_state <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          // Shadows are sampled before any same-edge shadow write lands
          for (int k = 0; k < NUM_CH; k++) begin
            r_live_incr[k*PHASE_W +: PHASE_W] <= r_sh_incr[k];
            r_live_offs[k*PHASE_W +: PHASE_W] <= r_sh_offs[k];
          end
          r_live_gain    <= r_sh_gain;
          r_commit_cnt   <= r_commit_cnt + 16'd1;
          r_update_pulse <= 1'b1;
          r_state        <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Shadow registers accept writes in every FSM state
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      r_sh_gain <= c_GAIN_RST;
      for (int k = 0; k < NUM_CH; k++) begin
        r_sh_incr[k] <= '0;
        r_sh_offs[k] <= '0;
      end
    end else begin
      if (w_gain_wr) begin
        r_sh_gain <= avs_writedata[GAIN_W-1:0];
      end
      for (int k = 0; k < NUM_CH; k++) begin
        if (w_incr_wr && (w_ch == 4'(k))) begin
          r_sh_incr[k] <= avs_writedata[PHASE_W-1:0];
        end
        if (w_offs_wr && (w_ch == 4'(k))) begin
          r_sh_offs[k] <= avs_writedata[PHASE_W-1:0];
        end
      end
    end
  end

`ifdef LOCKIN_REGS_READBACK_EN
  logic [31:0] w_rd_mux;

  always_comb begin
    w_rd_mux = 32'd0;
    if (avs_address == c_ADDR_STATUS) begin
      w_rd_mux = {r_commit_cnt, 15'd0, w_pending};
    end else if (avs_address == c_ADDR_GAIN) begin
      w_rd_mux = 32'(r_sh_gain);
    end
    for (int k = 0; k < NUM_CH; k++) begin
      if (avs_address == 6'(16 + k)) begin
        w_rd_mux = 32'(r_sh_incr[k]);
      end
      if (avs_address == 6'(32 + k)) begin
        w_rd_mux = 32'(r_sh_offs[k]);
      end
    end
  end

  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      r_rdata   <= 32'd0;
      r_rdvalid <= 1'b0;
    end else begin
      r_rdata   <= avs_read ? w_rd_mux : 32'd0;
      r_rdvalid <= avs_read;
    end
  end
`else
  logic w_unused_cnt;
  assign w_unused_cnt = ^r_commit_cnt;

  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      r_rdata   <= 32'd0;
      r_rdvalid <= 1'b0;
    end else begin
      r_rdata   <= 32'd0;
      r_rdvalid <= avs_read;
    end
  end
`endif

  assign avs_readdata      = r_rdata;
  assign avs_readdatavalid = r_rdvalid;
  assign phase_incr        = r_live_incr;
  assign phase_offs        = r_live_offs;
  assign gain_ctrl         = r_live_gain;
  assign update_pulse      = r_update_pulse;
  assign commit_pending    = w_pending;

endmodule
`default_nettype wire

// File: tb/tb_lockin_ctrl_regs.sv
`default_nettype none
// ============================================================================
// Module   : tb_lockin_ctrl_regs
// Purpose  : Self-checking bench: directed scenarios plus randomized traffic
//            compared every cycle against a behavioural register-bank model.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_lockin_ctrl_regs;

  localparam int NUM_CH   = 8;
  localparam int PHASE_W  = 20;
  localparam int GAIN_W   = 6;
  localparam int GAIN_RST = 5;
`ifdef LOCKIN_REGS_READBACK_EN
  localparam bit RB = 1'b1;
`else
  localparam bit RB = 1'b0;
`endif
  localparam int unsigned PMASK = (PHASE_W == 32) ? 32'hFFFF_FFFF : ((32'd1 << PHASE_W) - 1);
  localparam int unsigned GMASK = (32'd1 << GAIN_W) - 1;

  logic                      clk_clk = 1'b0;
  logic                      reset_reset;
  logic [5:0]                avs_address;
  logic                      avs_write;
  logic [31:0]               avs_writedata;
  logic                      avs_read;
  logic [31:0]               avs_readdata;
  logic                      avs_readdatavalid;
  logic                      sync_strobe;
  logic [NUM_CH*PHASE_W-1:0] phase_incr;
  logic [NUM_CH*PHASE_W-1:0] phase_offs;
  logic [GAIN_W-1:0]         gain_ctrl;
  logic                      update_pulse;
  logic                      commit_pending;

  lockin_ctrl_regs #(
    .NUM_CH  (NUM_CH),
    .PHASE_W (PHASE_W),
    .GAIN_W  (GAIN_W),
    .GAIN_RST(GAIN_RST)
  ) dut (
    .clk_clk          (clk_clk),
    .reset_reset      (reset_reset),
    .avs_address      (avs_address),
    .avs_write        (avs_write),
    .avs_writedata    (avs_writedata),
    .avs_read         (avs_read),
    .avs_readdata     (avs_readdata),
    .avs_readdatavalid(avs_readdatavalid),
    .sync_strobe      (sync_strobe),
    .phase_incr       (phase_incr),
    .phase_offs       (phase_offs),
    .gain_ctrl        (gain_ctrl),
    .update_pulse     (update_pulse),
    .commit_pending   (commit_pending)
  );

  always #5 clk_clk = ~clk_clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Behavioural model: register contents plus two flags for "armed" and
  // "copy happens on the next edge"
  int unsigned m_sh_incr  [NUM_CH];
  int unsigned m_sh_offs  [NUM_CH];
  int unsigned m_live_incr[NUM_CH];
  int unsigned m_live_offs[NUM_CH];
  int unsigned m_sh_gain, m_gain, m_cnt, m_rdata;
  bit          m_armed, m_loading, m_pulse, m_rdvalid;
  bit          m_ok = 1'b0;

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int unsigned mread(input int a);
    if (!RB) return 0;
    if (a == 1) return (m_cnt << 16) | 32'(m_armed || m_loading);
    if (a == 2) return m_sh_gain;
    if (a >= 16 && a < 16 + NUM_CH) return m_sh_incr[a-16];
    if (a >= 32 && a < 32 + NUM_CH) return m_sh_offs[a-32];
    return 0;
  endfunction

  task automatic model_edge();
    int          a;
    int unsigned wd;
    bit          cw, ab, cm, im, was_loading, was_armed;
    if (reset_reset) begin
      for (int k = 0; k < NUM_CH; k++) begin
        m_sh_incr[k] = 0; m_sh_offs[k] = 0; m_live_incr[k] = 0; m_live_offs[k] = 0;
      end
      m_sh_gain = GAIN_RST; m_gain = GAIN_RST; m_cnt = 0; m_rdata = 0;
      m_armed = 0; m_loading = 0; m_pulse = 0; m_rdvalid = 0; m_ok = 1;
      return;
    end
    a  = int'(avs_address);
    wd = avs_writedata;
    was_loading = m_loading;
    was_armed   = m_armed;
    m_rdvalid = avs_read;
    m_rdata   = avs_read ? mread(a) : 0;
    m_pulse   = was_loading;
    if (was_loading) begin
      for (int k = 0; k < NUM_CH; k++) begin
        m_live_incr[k] = m_sh_incr[k];
        m_live_offs[k] = m_sh_offs[k];
      end
      m_gain    = m_sh_gain;
      m_cnt     = (m_cnt + 1) & 32'hFFFF;
      m_loading = 0;
    end else begin
      cw = avs_write && (a == 0);
      ab = cw && wd[2];
      cm = cw && wd[0] && !wd[2];
      im = wd[1];
      if (was_armed) begin
        if (ab) m_armed = 0;
        else if (sync_strobe || (cm && im)) begin
          m_armed = 0; m_loading = 1;
        end
      end else if (cm) begin
        if (im) m_loading = 1;
        else m_armed = 1;
      end
    end
    if (avs_write) begin
      if (a == 2) m_sh_gain = wd & GMASK;
      if (a >= 16 && a < 16 + NUM_CH) m_sh_incr[a-16] = wd & PMASK;
      if (a >= 32 && a < 32 + NUM_CH) m_sh_offs[a-32] = wd & PMASK;
    end
  endtask

  // Every-cycle comparison of all outputs against the model
  logic [NUM_CH*PHASE_W-1:0] e_incr, e_offs;
  always @(negedge clk_clk) begin
    if (m_ok) begin
      for (int k = 0; k < NUM_CH; k++) begin
        e_incr[k*PHASE_W +: PHASE_W] = PHASE_W'(m_live_incr[k]);
        e_offs[k*PHASE_W +: PHASE_W] = PHASE_W'(m_live_offs[k]);
      end
      chk("m_phase_incr", 256'(phase_incr), 256'(e_incr));
      chk("m_phase_offs", 256'(phase_offs), 256'(e_offs));
      chk("m_gain", 256'(gain_ctrl), 256'(m_gain));
      chk("m_pulse", 256'(update_pulse), 256'(m_pulse));
      chk("m_pending", 256'(commit_pending), 256'(m_armed || m_loading));
      chk("m_rdvalid", 256'(avs_readdatavalid), 256'(m_rdvalid));
      chk("m_rdata", 256'(avs_readdata), 256'(m_rdata));
    end
  end

  task automatic cyc();
    @(posedge clk_clk);
    model_edge();
    @(negedge clk_clk);
  endtask

  task automatic wr(input logic [5:0] a, input logic [31:0] d);
    avs_address = a; avs_writedata = d; avs_write = 1'b1;
    cyc();
    avs_write = 1'b0;
  endtask

  task automatic rd(input logic [5:0] a);
    avs_address = a; avs_read = 1'b1;
    cyc();
    avs_read = 1'b0;
  endtask

  task automatic sync_pulse();
    sync_strobe = 1'b1;
    cyc();
    sync_strobe = 1'b0;
  endtask

  initial begin
    reset_reset = 1'b1; avs_address = '0; avs_write = 1'b0; avs_writedata = '0;
    avs_read = 1'b0; sync_strobe = 1'b0;
    cyc(); cyc();
    reset_reset = 1'b0;

    // Reset state
    chk("rst_gain", 256'(gain_ctrl), 256'(5));
    chk("rst_incr", 256'(phase_incr), 256'(0));
    chk("rst_offs", 256'(phase_offs), 256'(0));
    chk("rst_pending", 256'(commit_pending), 256'(0));

    // Immediate commit
    wr(6'h10, 32'h0001_2345);
    wr(6'h00, 32'h3);
    chk("imm_before", 256'(phase_incr[19:0]), 256'(0));
    cyc();
    chk("imm_live", 256'(phase_incr[19:0]), 256'(20'h12345));
    chk("imm_pulse_hi", 256'(update_pulse), 256'(1));
    cyc();
    chk("imm_pulse_lo", 256'(update_pulse), 256'(0));
    rd(6'h01);
    chk("status_valid", 256'(avs_readdatavalid), 256'(1));
    chk("status_data", 256'(avs_readdata), 256'(RB ? 32'h0001_0000 : 32'h0));
    cyc();
    chk("status_valid_lo", 256'(avs_readdatavalid), 256'(0));

    // Armed commit waiting for sync
    wr(6'h21, 32'h0000_0ABC);
    wr(6'h00, 32'h1);
    repeat (10) cyc();
    chk("arm_hold", 256'(phase_offs[39:20]), 256'(0));
    chk("arm_pending", 256'(commit_pending), 256'(1));
    sync_pulse();
    chk("sync_load_cycle", 256'(phase_offs[39:20]), 256'(0));
    cyc();
    chk("sync_live", 256'(phase_offs[39:20]), 256'(20'hABC));
    chk("sync_pending", 256'(commit_pending), 256'(0));

    // Abort while armed
    wr(6'h11, 32'h777);
    wr(6'h00, 32'h1);
    wr(6'h00, 32'h5);
    chk("abort_pending", 256'(commit_pending), 256'(0));
    sync_pulse();
    for (int i = 0; i < 3; i++) begin
      chk("abort_no_pulse", 256'(update_pulse), 256'(0));
      cyc();
    end
    chk("abort_no_load", 256'(phase_incr[39:20]), 256'(0));

    // Out-of-range channel
    wr(6'h18, 32'h000F_FFFF);
    rd(6'h18);
    chk("oor_valid", 256'(avs_readdatavalid), 256'(1));
    chk("oor_data", 256'(avs_readdata), 256'(0));
    cyc();
    chk("oor_valid_lo", 256'(avs_readdatavalid), 256'(0));

    // Reset while armed
    wr(6'h12, 32'h55);
    wr(6'h00, 32'h1);
    reset_reset = 1'b1;
    cyc();
    reset_reset = 1'b0;
    sync_pulse();
    cyc();
    chk("rstarm_incr", 256'(phase_incr), 256'(0));
    chk("rstarm_offs", 256'(phase_offs), 256'(0));
    chk("rstarm_gain", 256'(gain_ctrl), 256'(5));
    chk("rstarm_pending", 256'(commit_pending), 256'(0));
    chk("rstarm_pulse", 256'(update_pulse), 256'(0));

    // Randomized traffic
    for (int i = 0; i < 4000; i++) begin
      int sel;
      reset_reset = ($urandom_range(0, 299) == 0);
      sync_strobe = ($urandom_range(0, 7) == 0);
      avs_write   = ($urandom_range(0, 2) != 0);
      avs_read    = ($urandom_range(0, 2) == 0);
      avs_writedata = $urandom;
      sel = $urandom_range(0, 9);
      case (sel)
        0, 1:    begin avs_address = 6'h00; avs_writedata = 32'($urandom_range(0, 7)); end
        2:       avs_address = 6'h01;
        3:       avs_address = 6'h02;
        4, 5:    avs_address = 6'(16 + $urandom_range(0, 15));
        6, 7:    avs_address = 6'(32 + $urandom_range(0, 15));
        default: avs_address = 6'($urandom_range(0, 63));
      endcase
      cyc();
    end
    reset_reset = 1'b0; avs_write = 1'b0; avs_read = 1'b0; sync_strobe = 1'b0;
    repeat (3) cyc();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
